// File: rtl/safebox_pkg.sv
// Shared keypad definitions for the safebox scanner and its key-side emulator:
// key width, emulator FSM encodings and the key -> (row, col) line mapping.
package safebox_pkg;

  localparam int KEY_W = 4;

  localparam logic [4:0] ST_IDLE           = 5'b00001;
  localparam logic [4:0] ST_PRESS_BOUNCE   = 5'b00010;
  localparam logic [4:0] ST_HOLD           = 5'b00100;
  localparam logic [4:0] ST_RELEASE_BOUNCE = 5'b01000;
  localparam logic [4:0] ST_GAP            = 5'b10000;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } key_lines_t;

  // Active-low one-hot lines: column index is key[1:0], row index is key[3:2].
  function automatic key_lines_t key_to_lines(input logic [KEY_W-1:0] key);
    key_lines_t lines;
    lines.row = ~(4'b0001 << key[3:2]);
    lines.col = ~(4'b0001 << key[1:0]);
    return lines;
  endfunction

endpackage

// File: rtl/keypad_matrix_emulator_key_fifo.sv
// Small synchronous key-code FIFO; pointers carry one extra wrap bit so that
// full and empty are told apart without a separate flag.
module key_fifo
  import safebox_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [KEY_W-1:0]         din,
  output logic [KEY_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [KEY_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Key-side 4x4 matrix model: replays queued key codes as bounce/hold/bounce/gap
// presses and answers the scanner's active-low column drive on the row lines.
module keypad_matrix_emulator
  import safebox_pkg::*;
#(
  parameter int HOLD_CYCLES   = 2000000,
  parameter int GAP_CYCLES    = 2000000,
  parameter int BOUNCE_CYCLES = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    col,
  output logic [3:0]                    row,
  input  logic [KEY_W-1:0]              key_code,
  input  logic                          key_valid,
  output logic                          key_ready,
  input  logic                          abort,
  output logic                          busy,
  output logic                          key_done,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LD = HAS_BOUNCE ? CNT_W'(BOUNCE_CYCLES - 1) : '0;

  logic [4:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] cur_key;
  logic [KEY_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             contact_closed;
  key_lines_t       lines;

  assign pop       = (state == ST_IDLE) && !fifo_empty && !abort;
  assign key_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || (pending != '0);
  // Suppressed under abort so a flush landing on the last gap cycle reports nothing.
  assign key_done  = (state == ST_GAP) && (cnt == '0) && !abort;

  key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_key_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (key_valid),
    .pop   (pop),
    .flush (abort),
    .din   (key_code),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  always_comb begin
    contact_closed = 1'b0;
    case (state)
      ST_PRESS_BOUNCE:   contact_closed = ~cnt[0];
      ST_HOLD:           contact_closed = 1'b1;
      ST_RELEASE_BOUNCE: contact_closed = cnt[0];
      default:           contact_closed = 1'b0;
    endcase
  end

  // A closed contact shorts row r to column c, so row r follows col c when it is driven low.
  always_comb begin
    lines = key_to_lines(cur_key);
    row   = 4'hF;
    if (contact_closed && ((~col & ~lines.col) != 4'h0)) row = lines.row;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cur_key <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_key <= fifo_dout;
            if (HAS_BOUNCE) begin
              state <= ST_PRESS_BOUNCE;
              cnt   <= BOUNCE_LD;
            end else begin
              state <= ST_HOLD;
              cnt   <= HOLD_LD;
            end
          end
        end
        ST_PRESS_BOUNCE: begin
          if (cnt == '0) begin
            state <= ST_HOLD;
            cnt   <= HOLD_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            if (HAS_BOUNCE) begin
              state <= ST_RELEASE_BOUNCE;
              cnt   <= BOUNCE_LD;
            end else begin
              state <= ST_GAP;
              cnt   <= GAP_LD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RELEASE_BOUNCE: begin
          if (cnt == '0) begin
            state <= ST_GAP;
            cnt   <= GAP_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator: one instance without bounce, one with.
module tb_keypad_matrix_emulator;

  logic       clk = 1'b0;
  logic       rst;

  logic [3:0] col_a, row_a, kc_a;
  logic       kv_a, kr_a, ab_a, busy_a, kd_a;
  logic [2:0] pend_a;

  logic [3:0] col_b, row_b, kc_b;
  logic       kv_b, kr_b, ab_b, busy_b, kd_b;
  logic [2:0] pend_b;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  keypad_matrix_emulator #(
    .HOLD_CYCLES(20), .GAP_CYCLES(10), .BOUNCE_CYCLES(0), .FIFO_DEPTH(4)
  ) u_dut_a (
    .clk(clk), .rst(rst), .col(col_a), .row(row_a), .key_code(kc_a),
    .key_valid(kv_a), .key_ready(kr_a), .abort(ab_a), .busy(busy_a),
    .key_done(kd_a), .pending(pend_a)
  );

  keypad_matrix_emulator #(
    .HOLD_CYCLES(20), .GAP_CYCLES(10), .BOUNCE_CYCLES(8), .FIFO_DEPTH(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .col(col_b), .row(row_b), .key_code(kc_b),
    .key_valid(kv_b), .key_ready(kr_b), .abort(ab_b), .busy(busy_b),
    .key_done(kd_b), .pending(pend_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] row_idx(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (!r[i]) idx = 2'(i);
    return idx;
  endfunction

  // Scanner model: walk a single low column across the matrix and decode the hit.
  task automatic scan_a(output logic hit, output logic [3:0] key);
    hit = 1'b0;
    key = 4'h0;
    for (int c = 0; c < 4; c++) begin
      col_a = ~(4'b0001 << c);
      #1;
      if (row_a != 4'hF) begin
        hit = 1'b1;
        key = {row_idx(row_a), 2'(c)};
      end
    end
    col_a = 4'h0;
  endtask

  logic [3:0] burst_codes [4];
  logic [3:0] cap [$];
  logic       hit, prev_hit;
  logic [3:0] key;
  int first, last, low, kd_n, kd_at, other_bad, bad, n, ready_bad, closed;
  logic       exp_row0, exp_kd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    burst_codes = '{4'h3, 4'h5, 4'h8, 4'hB};
    rst = 1'b1;
    col_a = 4'h0; kc_a = 4'h0; kv_a = 1'b0; ab_a = 1'b0;
    col_b = 4'h0; kc_b = 4'h0; kv_b = 1'b0; ab_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_row_a",   32'(row_a),  'hF);
    check("rst_ready_a", 32'(kr_a),   1);
    check("rst_busy_a",  32'(busy_a), 0);
    check("rst_pend_a",  32'(pend_a), 0);
    check("rst_done_a",  32'(kd_a),   0);
    check("rst_row_b",   32'(row_b),  'hF);

    // Single key 9 against col 1101 (its column) and col 1110 (another column).
    col_a = 4'b1101; kc_a = 4'h9; kv_a = 1'b1;
    @(negedge clk);
    kv_a = 1'b0;
    first = -1; last = -1; low = 0; kd_n = 0; kd_at = -1; other_bad = 0; bad = 0;
    for (int i = 0; i < 45; i++) begin
      col_a = 4'b1110; #1;
      if (row_a != 4'hF) other_bad++;
      col_a = 4'b1101; #1;
      if (row_a == 4'b1011) begin
        low++;
        if (first < 0) first = i;
        last = i;
      end else if (row_a != 4'hF) bad++;
      if (kd_a) begin kd_n++; kd_at = i; end
      @(negedge clk);
    end
    check("single_first",     32'(first),         1);
    check("single_low_cnt",   32'(low),           20);
    check("single_contig",    32'(last - first),  19);
    check("single_bad_row",   32'(bad),           0);
    check("single_other_col", 32'(other_bad),     0);
    check("single_done_cnt",  32'(kd_n),          1);
    check("single_done_at",   32'(kd_at - first), 29);
    check("single_busy_end",  32'(busy_a),        0);

    // Password burst 3,5,8,B on consecutive cycles.
    col_a = 4'h0; prev_hit = 1'b0; kd_n = 0;
    for (int k = 0; k < 4; k++) begin
      kc_a = burst_codes[k]; kv_a = 1'b1;
      check("burst_ready", 32'(kr_a), 1);
      scan_a(hit, key);
      if (hit && !prev_hit) cap.push_back(key);
      prev_hit = hit;
      @(negedge clk);
    end
    kv_a = 1'b0;
    check("burst_pend_full", 32'(pend_a), 3);
    for (int i = 0; i < 200 && kd_n < 4; i++) begin
      scan_a(hit, key);
      if (hit && !prev_hit) cap.push_back(key);
      prev_hit = hit;
      if (kd_a) begin
        kd_n++;
        check("burst_pend", 32'(pend_a), 32'(4 - kd_n));
      end
      @(negedge clk);
    end
    check("burst_done_cnt", 32'(kd_n), 4);
    check("burst_cap_cnt",  32'(cap.size()), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < cap.size()) check("burst_key", 32'(cap[k]), 32'(burst_codes[k]));
      else                check("burst_key", 32'hDEAD, 32'(burst_codes[k]));
    end

    // Full FIFO: first code goes into HOLD, the next four fill the queue.
    col_a = 4'h0;
    kc_a = 4'h1; kv_a = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      kc_a = 4'(k + 2);
      check("full_fill_ready", 32'(kr_a), 1);
      @(negedge clk);
    end
    check("full_ready", 32'(kr_a),   0);
    check("full_pend",  32'(pend_a), 4);
    check("full_busy",  32'(busy_a), 1);
    kc_a = 4'h6;
    ready_bad = 0; kd_n = 0;
    for (int i = 0; i < 100 && kd_n == 0; i++) begin
      if (kr_a) ready_bad++;
      if (kd_a) kd_n = 1;
      else @(negedge clk);
    end
    check("full_stall_ready", 32'(ready_bad), 0);
    check("full_first_done",  32'(kd_n),      1);
    n = 0;
    while (!kr_a && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("full_accept_delay", 32'(n), 2);
    @(negedge clk);
    kv_a = 1'b0;
    check("full_accept_pend",  32'(pend_a), 4);
    check("full_accept_ready", 32'(kr_a),   0);
    ab_a = 1'b1;
    @(negedge clk);
    ab_a = 1'b0;
    check("flush_pend", 32'(pend_a), 0);
    check("flush_busy", 32'(busy_a), 0);

    // Abort during HOLD of key F with two codes queued.
    kc_a = 4'hF; kv_a = 1'b1; @(negedge clk);
    kc_a = 4'h1;              @(negedge clk);
    kc_a = 4'h2;              @(negedge clk);
    kv_a = 1'b0;
    repeat (4) @(negedge clk);
    col_a = 4'b0111; #1;
    check("abort_hold_row",  32'(row_a),  'h7);
    check("abort_hold_pend", 32'(pend_a), 2);
    col_a = 4'h0;
    ab_a = 1'b1;
    @(negedge clk);
    ab_a = 1'b0;
    #1;
    check("abort_row",   32'(row_a),  'hF);
    check("abort_pend",  32'(pend_a), 0);
    check("abort_busy",  32'(busy_a), 0);
    check("abort_ready", 32'(kr_a),   1);
    kd_n = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kd_a) kd_n++;
      if (row_a != 4'hF) bad++;
    end
    check("abort_no_done", 32'(kd_n), 0);
    check("abort_row_idle", 32'(bad), 0);

    // Bounce on key 0 with col held at 0000.
    col_b = 4'h0; kc_b = 4'h0; kv_b = 1'b1;
    @(negedge clk);
    kv_b = 1'b0;
    for (int i = 0; i < 48; i++) begin
      exp_kd = 1'b0;
      if (i == 0)       exp_row0 = 1'b1;
      else if (i <= 8)  exp_row0 = ((i - 1) % 2 == 0);
      else if (i <= 28) exp_row0 = 1'b0;
      else if (i <= 36) exp_row0 = ((i - 29) % 2 != 0);
      else begin
        exp_row0 = 1'b1;
        exp_kd   = (i == 46);
      end
      check("bounce_row", 32'(row_b), 32'({3'b111, exp_row0}));
      check("bounce_done", 32'(kd_b), 32'(exp_kd));
      @(negedge clk);
    end

    // Asynchronous reset while key 2 bounces, with one code still queued.
    col_b = 4'h0;
    kc_b = 4'h2; kv_b = 1'b1; @(negedge clk);
    kc_b = 4'h7;              @(negedge clk);
    kv_b = 1'b0;
    n = 0;
    while (row_b == 4'hF && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_pre_row",  32'(row_b),  'hE);
    check("rst_pre_pend", 32'(pend_b), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_row",   32'(row_b),  'hF);
    check("arst_ready", 32'(kr_b),   1);
    check("arst_busy",  32'(busy_b), 0);
    check("arst_pend",  32'(pend_b), 0);
    check("arst_done",  32'(kd_b),   0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    kc_b = 4'h2; kv_b = 1'b1;
    @(negedge clk);
    kv_b = 1'b0;
    closed = 0; bad = 0; kd_n = 0;
    for (int i = 0; i < 60; i++) begin
      if (row_b == 4'hE) closed++;
      else if (row_b != 4'hF) bad++;
      if (kd_b) kd_n++;
      @(negedge clk);
    end
    check("replay_closed", 32'(closed), 28);
    check("replay_bad",    32'(bad),    0);
    check("replay_done",   32'(kd_n),   1);
    check("replay_busy",   32'(busy_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
